// File: rtl/ifu_pkg.sv
// ----------------------------------------------------------------------------
// ifu_pkg
//
// Shared types and constants for the instruction-fetch controller.
//   ifuState_e       : fetch FSM state encoding (REQ, WAIT, HOLD, DROP)
//   XLEN_DEFAULT     : architectural PC / address width
//   INST_W           : fetched instruction width
//   RESET_PC_DEFAULT : fetch PC after reset
//   alignPc()        : clears the two low bits of a fetch target
// ----------------------------------------------------------------------------
package ifu_pkg;

    localparam int XLEN_DEFAULT = 64;
    localparam int INST_W       = 32;

    localparam logic [XLEN_DEFAULT-1:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

    // Fetch FSM states. DROP means a request is in flight whose response
    // belongs to a path abandoned by a redirect and must be swallowed.
    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_DROP = 2'd3
    } ifuState_e;

    // Instruction fetches are always word aligned; any low bits a redirect
    // source supplies are discarded rather than trapping here.
    function automatic logic [XLEN_DEFAULT-1:0] alignPc(input logic [XLEN_DEFAULT-1:0] addr);
        return {addr[XLEN_DEFAULT-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifu_ctrl_redir_arb.sv
// ----------------------------------------------------------------------------
// redir_arb
//
// Combinational redirect arbiter. A trap/mret redirect always wins over a
// branch redirect raised in the same cycle; the losing branch is simply lost,
// because the trap flushes the instruction that produced it anyway.
//
// Ports:
//   trap_en_i / trap_addr_i : trap redirect request and target
//   br_en_i   / br_addr_i   : branch redirect request and target
//   redir_any_o             : any redirect this cycle
//   redir_target_o          : selected, word-aligned redirect target
// ----------------------------------------------------------------------------
module redir_arb
    import ifu_pkg::*;
(
    input  logic [XLEN_DEFAULT-1:0] trap_addr_i,
    input  logic                    trap_en_i,
    input  logic [XLEN_DEFAULT-1:0] br_addr_i,
    input  logic                    br_en_i,
    output logic                    redir_any_o,
    output logic [XLEN_DEFAULT-1:0] redir_target_o
);

    // Priority select, then force word alignment on whichever target won.
    always_comb begin
        redir_any_o    = trap_en_i | br_en_i;
        redir_target_o = trap_en_i ? alignPc(trap_addr_i) : alignPc(br_addr_i);
    end

endmodule

// File: rtl/ifu_ctrl.sv
// ----------------------------------------------------------------------------
// ifu_ctrl
//
// Instruction-fetch controller. Owns the architectural fetch PC, issues one
// instruction-memory request at a time, and hands each fetched instruction to
// decode over a valid/ready handshake. Trap and branch redirects are merged
// (trap wins) and any response made stale by a redirect is discarded.
//
// Ports:
//   clk, rst                              : clock, async active-high reset
//   redir_trap_en_i / redir_trap_addr_i   : trap/mret redirect
//   redir_br_en_i   / redir_br_addr_i     : branch/jump redirect
//   imem_req_valid_o / imem_req_addr_o    : fetch request to memory
//   imem_req_ready_i                      : memory accepts request
//   imem_rsp_valid_i / imem_rsp_data_i    : fetch response
//   if_valid_o / if_pc_o / if_inst_o      : instruction to decode
//   if_ready_i                            : decode accepts instruction
//   pc_o                                  : current fetch PC
//   fetch_cnt_o                           : completed decode transfers
// ----------------------------------------------------------------------------
module ifu_ctrl
    import ifu_pkg::*;
#(
    parameter logic [XLEN_DEFAULT-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    redir_trap_en_i,
    input  logic [XLEN_DEFAULT-1:0] redir_trap_addr_i,
    input  logic                    redir_br_en_i,
    input  logic [XLEN_DEFAULT-1:0] redir_br_addr_i,

    output logic                    imem_req_valid_o,
    output logic [XLEN_DEFAULT-1:0] imem_req_addr_o,
    input  logic                    imem_req_ready_i,
    input  logic                    imem_rsp_valid_i,
    input  logic [INST_W-1:0]       imem_rsp_data_i,

    output logic                    if_valid_o,
    output logic [XLEN_DEFAULT-1:0] if_pc_o,
    output logic [INST_W-1:0]       if_inst_o,
    input  logic                    if_ready_i,

    output logic [XLEN_DEFAULT-1:0] pc_o,
    output logic [63:0]             fetch_cnt_o
);

    ifuState_e                 state_q, state_d;
    logic [XLEN_DEFAULT-1:0]   pc_q, pc_d;
    logic [XLEN_DEFAULT-1:0]   ifPc_q, ifPc_d;
    logic [INST_W-1:0]         ifInst_q, ifInst_d;
    logic [63:0]               fetchCnt_q, fetchCnt_d;

    logic                      redirAny;
    logic [XLEN_DEFAULT-1:0]   redirTarget;

    redir_arb u_redir_arb (
        .trap_addr_i    (redir_trap_addr_i),
        .trap_en_i      (redir_trap_en_i),
        .br_addr_i      (redir_br_addr_i),
        .br_en_i        (redir_br_en_i),
        .redir_any_o    (redirAny),
        .redir_target_o (redirTarget)
    );

    // State register. Memory shares this reset, so returning straight to REQ
    // cannot leave an orphaned response behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_REQ;
            pc_q       <= RESET_PC;
            ifPc_q     <= '0;
            ifInst_q   <= '0;
            fetchCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ifPc_q     <= ifPc_d;
            ifInst_q   <= ifInst_d;
            fetchCnt_q <= fetchCnt_d;
        end
    end

    // Next-state logic. A redirect overwrites the PC in every state; what it
    // does to the FSM depends on whether a request is already in flight.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ifPc_d     = ifPc_q;
        ifInst_d   = ifInst_q;
        fetchCnt_d = fetchCnt_q;

        unique case (state_q)
            ST_REQ: begin
                // An accepted request with a simultaneous redirect is for the
                // old path, so its response has to be dropped.
                if (imem_req_ready_i) begin
                    state_d = redirAny ? ST_DROP : ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (imem_rsp_valid_i) begin
                    if (redirAny) begin
                        state_d = ST_REQ;
                    end else begin
                        state_d  = ST_HOLD;
                        ifPc_d   = pc_q;
                        ifInst_d = imem_rsp_data_i;
                        pc_d     = pc_q + XLEN_DEFAULT'(4);
                    end
                end else if (redirAny) begin
                    state_d = ST_DROP;
                end
            end

            ST_HOLD: begin
                // The held instruction is squashed by a redirect even if decode
                // was ready, so neither the transfer nor the count happen.
                if (redirAny) begin
                    state_d = ST_REQ;
                end else if (if_ready_i) begin
                    state_d    = ST_REQ;
                    fetchCnt_d = fetchCnt_q + 64'd1;
                end
            end

            ST_DROP: begin
                if (imem_rsp_valid_i) begin
                    state_d = ST_REQ;
                end
            end

            default: begin
                state_d = ST_REQ;
            end
        endcase

        if (redirAny) begin
            pc_d = redirTarget;
        end
    end

    // Outputs are decoded from registered state; only if_valid_o sees the
    // live redirect so decode never consumes a squashed instruction.
    always_comb begin
        imem_req_valid_o = (state_q == ST_REQ);
        imem_req_addr_o  = pc_q;
        if_valid_o       = (state_q == ST_HOLD) && !redirAny;
        if_pc_o          = ifPc_q;
        if_inst_o        = ifInst_q;
        pc_o             = pc_q;
        fetch_cnt_o      = fetchCnt_q;
    end

endmodule

// File: tb/tb_ifu_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ifu_ctrl
//
// Directed, table-driven bench for ifu_ctrl. Each table row holds the inputs
// for one clock cycle and the outputs expected during that cycle (before the
// next rising edge). A short hand-written sequence covers asynchronous reset.
// ----------------------------------------------------------------------------
module tb_ifu_ctrl;

    typedef struct {
        logic        trapEn;
        logic [63:0] trapAddr;
        logic        brEn;
        logic [63:0] brAddr;
        logic        reqReady;
        logic        rspValid;
        logic [31:0] rspData;
        logic        ifReady;
        logic        expReqValid;
        logic [63:0] expReqAddr;
        logic        expIfValid;
        logic [63:0] expIfPc;
        logic [31:0] expIfInst;
        logic [63:0] expPc;
        logic [63:0] expCnt;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        redirTrapEn;
    logic [63:0] redirTrapAddr;
    logic        redirBrEn;
    logic [63:0] redirBrAddr;
    logic        imemReqValid;
    logic [63:0] imemReqAddr;
    logic        imemReqReady;
    logic        imemRspValid;
    logic [31:0] imemRspData;
    logic        ifValid;
    logic [63:0] ifPc;
    logic [31:0] ifInst;
    logic        ifReady;
    logic [63:0] pcOut;
    logic [63:0] fetchCnt;

    int testsRun;
    int testsFailed;
    vec_t vecs[$];

    ifu_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .redir_trap_en_i   (redirTrapEn),
        .redir_trap_addr_i (redirTrapAddr),
        .redir_br_en_i     (redirBrEn),
        .redir_br_addr_i   (redirBrAddr),
        .imem_req_valid_o  (imemReqValid),
        .imem_req_addr_o   (imemReqAddr),
        .imem_req_ready_i  (imemReqReady),
        .imem_rsp_valid_i  (imemRspValid),
        .imem_rsp_data_i   (imemRspData),
        .if_valid_o        (ifValid),
        .if_pc_o           (ifPc),
        .if_inst_o         (ifInst),
        .if_ready_i        (ifReady),
        .pc_o              (pcOut),
        .fetch_cnt_o       (fetchCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] NOP = 32'h0000_0013;

    function automatic vec_t mk(
        input logic tEn, input logic [63:0] tAddr,
        input logic bEn, input logic [63:0] bAddr,
        input logic rdy, input logic rsp, input logic [31:0] data, input logic ifr,
        input logic eReqV, input logic [63:0] eAddr, input logic eIfV,
        input logic [63:0] eIfPc, input logic [31:0] eInst,
        input logic [63:0] ePc, input logic [63:0] eCnt);
        vec_t v;
        v.trapEn = tEn;   v.trapAddr = tAddr;
        v.brEn = bEn;     v.brAddr = bAddr;
        v.reqReady = rdy; v.rspValid = rsp; v.rspData = data; v.ifReady = ifr;
        v.expReqValid = eReqV; v.expReqAddr = eAddr; v.expIfValid = eIfV;
        v.expIfPc = eIfPc; v.expIfInst = eInst; v.expPc = ePc; v.expCnt = eCnt;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        redirTrapEn   = v.trapEn;
        redirTrapAddr = v.trapAddr;
        redirBrEn     = v.brEn;
        redirBrAddr   = v.brAddr;
        imemReqReady  = v.reqReady;
        imemRspValid  = v.rspValid;
        imemRspData   = v.rspData;
        ifReady       = v.ifReady;
    endtask

    task automatic checkVector(input int idx, input vec_t v);
        checkOutput($sformatf("v%0d req_valid", idx), 64'(imemReqValid), 64'(v.expReqValid));
        checkOutput($sformatf("v%0d req_addr", idx), imemReqAddr, v.expReqAddr);
        checkOutput($sformatf("v%0d if_valid", idx), 64'(ifValid), 64'(v.expIfValid));
        checkOutput($sformatf("v%0d if_pc", idx), ifPc, v.expIfPc);
        checkOutput($sformatf("v%0d if_inst", idx), 64'(ifInst), 64'(v.expIfInst));
        checkOutput($sformatf("v%0d pc", idx), pcOut, v.expPc);
        checkOutput($sformatf("v%0d fetch_cnt", idx), fetchCnt, v.expCnt);
    endtask

    task automatic idleInputs();
        vec_t v;
        v = mk(0, 64'h0, 0, 64'h0, 0, 0, 32'h0, 0, 0, 64'h0, 0, 64'h0, 32'h0, 64'h0, 64'h0);
        applyStimulus(v);
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst = 1'b1;
        idleInputs();

        //          tEn tAddr                  bEn bAddr                  rdy rsp data          ifr | rqV addr                   ifV ifPc                   inst          pc                     cnt
        // three back-to-back fetches with a 1-cycle memory
        vecs.push_back(mk(0, 64'h0,                0, 64'h0,                1, 0, 32'h0,        0,  1, 64'h8000_0000,          0, 64'h0,                  32'h0,        64'h8000_0000,          64'd0));
        vecs.push_back(mk(0, 64'h0,                0, 64'h0,                0, 1, NOP,          0,  0, 64'h8000_0000,          0, 64'h0,                  32'h0,        64'h8000_0000,          64'd0));
        vecs.push_back(mk(0, 64'h0,                0, 64'h0,                0, 0, 32'h0,        1,  0, 64'h8000_0004,          1, 64'h8000_0000,          NOP,          64'h8000_0004,          64'd0));
        vecs.push_back(mk(0, 64'h0,                0, 64'h0,                1, 0, 32'h0,        0,  1, 64'h8000_0004,          0, 64'h8000_0000,          NOP,          64'h8000_0004,          64'd1));
        vecs.push_back(mk(0, 64'h0,                0, 64'h0,                0, 1, NOP,          0,  0, 64'h8000_0004,          0, 64'h8000_0000,          NOP,          64'h8000_0004,          64'd1));
        vecs.push_back(mk(0, 64'h0,                0, 64'h0,                0, 0, 32'h0,        1,  0, 64'h8000_0008,          1, 64'h8000_0004,          NOP,          64'h8000_0008,          64'd1));
        vecs.push_back(mk(0, 64'h0,                0, 64'h0,                1, 0, 32'h0,        0,  1, 64'h8000_0008,          0, 64'h8000_0004,          NOP,          64'h8000_0008,          64'd2));
        vecs.push_back(mk(0, 64'h0,                0, 64'h0,                0, 1, NOP,          0,  0, 64'h8000_0008,          0, 64'h8000_0004,          NOP,          64'h8000_0008,          64'd2));
        vecs.push_back(mk(0, 64'h0,                0, 64'h0,                0, 0, 32'h0,        1,  0, 64'h8000_000C,          1, 64'h8000_0008,          NOP,          64'h8000_000C,          64'd2));
        // fourth request accepted, then branch (misaligned target) while waiting
        vecs.push_back(mk(0, 64'h0,                0, 64'h0,                1, 0, 32'h0,        0,  1, 64'h8000_000C,          0, 64'h8000_0008,          NOP,          64'h8000_000C,          64'd3));
        vecs.push_back(mk(0, 64'h0,                1, 64'h8000_1002,        0, 0, 32'h0,        0,  0, 64'h8000_000C,          0, 64'h8000_0008,          NOP,          64'h8000_000C,          64'd3));
        // stale response swallowed in DROP
        vecs.push_back(mk(0, 64'h0,                0, 64'h0,                0, 1, 32'hDEAD_BEEF, 1, 0, 64'h8000_1000,          0, 64'h8000_0008,          NOP,          64'h8000_1000,          64'd3));
        vecs.push_back(mk(0, 64'h0,                0, 64'h0,                0, 0, 32'h0,        0,  1, 64'h8000_1000,          0, 64'h8000_0008,          NOP,          64'h8000_1000,          64'd3));
        // trap and branch together in REQ: trap wins
        vecs.push_back(mk(1, 64'h8000_0100,        1, 64'h8000_2000,        0, 0, 32'h0,        0,  1, 64'h8000_1000,          0, 64'h8000_0008,          NOP,          64'h8000_1000,          64'd3));
        // ready low 4 cycles, branch on the 3rd
        vecs.push_back(mk(0, 64'h0,                0, 64'h0,                0, 0, 32'h0,        0,  1, 64'h8000_0100,          0, 64'h8000_0008,          NOP,          64'h8000_0100,          64'd3));
        vecs.push_back(mk(0, 64'h0,                0, 64'h0,                0, 0, 32'h0,        0,  1, 64'h8000_0100,          0, 64'h8000_0008,          NOP,          64'h8000_0100,          64'd3));
        vecs.push_back(mk(0, 64'h0,                1, 64'h8000_0400,        0, 0, 32'h0,        0,  1, 64'h8000_0100,          0, 64'h8000_0008,          NOP,          64'h8000_0100,          64'd3));
        vecs.push_back(mk(0, 64'h0,                0, 64'h0,                0, 0, 32'h0,        0,  1, 64'h8000_0400,          0, 64'h8000_0008,          NOP,          64'h8000_0400,          64'd3));
        vecs.push_back(mk(0, 64'h0,                0, 64'h0,                1, 0, 32'h0,        0,  1, 64'h8000_0400,          0, 64'h8000_0008,          NOP,          64'h8000_0400,          64'd3));
        vecs.push_back(mk(0, 64'h0,                0, 64'h0,                0, 1, 32'h0010_0093, 0, 0, 64'h8000_0400,          0, 64'h8000_0008,          NOP,          64'h8000_0400,          64'd3));
        // HOLD stalled by decode for 5 cycles
        for (int i = 0; i < 5; i++) begin
            vecs.push_back(mk(0, 64'h0,            0, 64'h0,                0, 0, 32'h0,        0,  0, 64'h8000_0404,          1, 64'h8000_0400,          32'h0010_0093, 64'h8000_0404,         64'd3));
        end
        // redirect in HOLD while decode is ready: no transfer, no count
        vecs.push_back(mk(0, 64'h0,                1, 64'h8000_0800,        0, 0, 32'h0,        1,  0, 64'h8000_0404,          0, 64'h8000_0400,          32'h0010_0093, 64'h8000_0404,         64'd3));
        vecs.push_back(mk(0, 64'h0,                0, 64'h0,                1, 0, 32'h0,        1,  1, 64'h8000_0800,          0, 64'h8000_0400,          32'h0010_0093, 64'h8000_0800,         64'd3));
        // response and redirect in the same WAIT cycle: response discarded
        vecs.push_back(mk(0, 64'h0,                1, 64'h8000_0C00,        0, 1, 32'h1111_1111, 0, 0, 64'h8000_0800,          0, 64'h8000_0400,          32'h0010_0093, 64'h8000_0800,         64'd3));
        // accepted request and trap in the same REQ cycle: DROP
        vecs.push_back(mk(1, 64'h8000_0200,        0, 64'h0,                1, 0, 32'h0,        0,  1, 64'h8000_0C00,          0, 64'h8000_0400,          32'h0010_0093, 64'h8000_0C00,         64'd3));
        vecs.push_back(mk(0, 64'h0,                0, 64'h0,                0, 0, 32'h0,        0,  0, 64'h8000_0200,          0, 64'h8000_0400,          32'h0010_0093, 64'h8000_0200,         64'd3));
        vecs.push_back(mk(0, 64'h0,                0, 64'h0,                0, 1, 32'h2222_2222, 0, 0, 64'h8000_0200,          0, 64'h8000_0400,          32'h0010_0093, 64'h8000_0200,         64'd3));
        // spurious response in REQ ignored
        vecs.push_back(mk(0, 64'h0,                0, 64'h0,                0, 1, 32'h3333_3333, 0, 1, 64'h8000_0200,          0, 64'h8000_0400,          32'h0010_0093, 64'h8000_0200,         64'd3));
        // trap to top of address space (low bits cleared), then pc+4 wraps to 0
        vecs.push_back(mk(1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'h0,             0, 0, 32'h0,        0,  1, 64'h8000_0200,          0, 64'h8000_0400,          32'h0010_0093, 64'h8000_0200,         64'd3));
        vecs.push_back(mk(0, 64'h0,                0, 64'h0,                1, 0, 32'h0,        0,  1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h8000_0400,          32'h0010_0093, 64'hFFFF_FFFF_FFFF_FFFC, 64'd3));
        vecs.push_back(mk(0, 64'h0,                0, 64'h0,                0, 1, 32'h0000_0073, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h8000_0400,          32'h0010_0093, 64'hFFFF_FFFF_FFFF_FFFC, 64'd3));
        vecs.push_back(mk(0, 64'h0,                0, 64'h0,                0, 0, 32'h0,        1,  0, 64'h0,                  1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0000_0073, 64'h0,                  64'd3));
        vecs.push_back(mk(0, 64'h0,                0, 64'h0,                0, 0, 32'h0,        0,  1, 64'h0,                  0, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0000_0073, 64'h0,                  64'd4));

        // Reset state before any clock edge is released
        @(negedge clk);
        #1;
        checkOutput("reset req_valid", 64'(imemReqValid), 64'd1);
        checkOutput("reset req_addr", imemReqAddr, 64'h8000_0000);
        checkOutput("reset if_valid", 64'(ifValid), 64'd0);
        checkOutput("reset fetch_cnt", fetchCnt, 64'd0);

        // Release reset away from the rising edge; next posedge is cycle 0
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkVector(i, vecs[i]);
            @(negedge clk);
        end

        // Asynchronous reset while WAIT holds a pending request
        idleInputs();
        imemReqReady = 1'b1;
        @(negedge clk);
        idleInputs();
        #1;
        checkOutput("pre-reset in WAIT req_valid", 64'(imemReqValid), 64'd0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async reset req_valid", 64'(imemReqValid), 64'd1);
        checkOutput("async reset pc", pcOut, 64'h8000_0000);
        checkOutput("async reset if_pc", ifPc, 64'h0);
        checkOutput("async reset if_inst", 64'(ifInst), 64'h0);
        checkOutput("async reset fetch_cnt", fetchCnt, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        imemReqReady = 1'b1;
        #1;
        checkOutput("post-reset req_addr", imemReqAddr, 64'h8000_0000);
        @(negedge clk);
        imemReqReady = 1'b0;
        #1;
        checkOutput("post-reset accepted to WAIT", 64'(imemReqValid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
